// File: rtl/display_pkg.sv
// display_pkg: shared types and segment patterns for the display multiplexer.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'b1000000;
    localparam seg7_t SEG_1     = 7'b1111001;
    localparam seg7_t SEG_2     = 7'b0100100;
    localparam seg7_t SEG_3     = 7'b0110000;
    localparam seg7_t SEG_4     = 7'b0011001;
    localparam seg7_t SEG_5     = 7'b0010010;
    localparam seg7_t SEG_6     = 7'b0000010;
    localparam seg7_t SEG_7     = 7'b1111000;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0010000;
    localparam seg7_t SEG_A     = 7'b0001000;
    localparam seg7_t SEG_B     = 7'b0000011;
    localparam seg7_t SEG_C     = 7'b1000110;
    localparam seg7_t SEG_D     = 7'b0100001;
    localparam seg7_t SEG_E     = 7'b0000110;
    localparam seg7_t SEG_F     = 7'b0001110;
    localparam seg7_t SEG_BLANK = 7'b1111111;

    // Convert an active-low pattern to the requested output polarity.
    function automatic seg7_t seg_polarity(input seg7_t pat_n, input logic active_low);
        return active_low ? pat_n : ~pat_n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low 7-segment pattern.
// Hex letters A..F exist only when DISPLAY_MUX_HEX_EN is defined; otherwise
// nibbles 10..15 are blank and the letter decode is not built.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_en,
    input  logic       i_blank,
    output seg7_t      o_seg_n
);

    seg7_t w_pat;

`ifndef DISPLAY_MUX_HEX_EN
    logic w_unused_hex_en;
    assign w_unused_hex_en = i_hex_en;
`endif

    // Pattern lookup; anything not decoded falls back to blank.
    always_comb begin
        w_pat = SEG_BLANK;
        case (i_nibble)
            4'h0:    w_pat = SEG_0;
            4'h1:    w_pat = SEG_1;
            4'h2:    w_pat = SEG_2;
            4'h3:    w_pat = SEG_3;
            4'h4:    w_pat = SEG_4;
            4'h5:    w_pat = SEG_5;
            4'h6:    w_pat = SEG_6;
            4'h7:    w_pat = SEG_7;
            4'h8:    w_pat = SEG_8;
            4'h9:    w_pat = SEG_9;
`ifdef DISPLAY_MUX_HEX_EN
            4'hA:    w_pat = i_hex_en ? SEG_A : SEG_BLANK;
            4'hB:    w_pat = i_hex_en ? SEG_B : SEG_BLANK;
            4'hC:    w_pat = i_hex_en ? SEG_C : SEG_BLANK;
            4'hD:    w_pat = i_hex_en ? SEG_D : SEG_BLANK;
            4'hE:    w_pat = i_hex_en ? SEG_E : SEG_BLANK;
            4'hF:    w_pat = i_hex_en ? SEG_F : SEG_BLANK;
`endif
            default: w_pat = SEG_BLANK;
        endcase
    end

    assign o_seg_n = i_blank ? SEG_BLANK : w_pat;

endmodule

// File: rtl/display_mux.sv
// display_mux: time-multiplexed 7-segment driver with frame-synchronous
// data update and optional leading-zero blanking.
// Build option: DISPLAY_MUX_HEX_EN enables A..F letter decode.
module display_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int LZB        = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    displayActive,
    output logic [6:0]              seg,
    output logic                    segDp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frameDone
);

    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          POL_LOW    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic          LZB_EN     = (LZB != 0) ? 1'b1 : 1'b0;

`ifdef DISPLAY_MUX_HEX_EN
    localparam logic          HEX_EN     = 1'b1;
`else
    localparam logic          HEX_EN     = 1'b0;
`endif

    // "Off" levels for each output under the selected polarity.
    localparam logic [6:0]            SEG_OFF = POL_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = POL_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = POL_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic                  r_frame_done;
    logic [DW-1:0]         r_pend_digits;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic                  r_pend_valid;
    logic [DW-1:0]         r_act_digits;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic [6:0]            r_seg;
    logic                  r_seg_dp;
    logic [NUM_DIGITS-1:0] r_anode;

    logic                  w_tick;
    logic                  w_wrap;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_lz;
    logic                  w_lz_run;
    logic                  w_lz_sel;
    logic                  w_blank;
    seg7_t                 w_seg_n;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    // Prescaler and digit index; the index steps once per scan period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= w_wrap ? '0 : r_idx + IW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Pending/active data path; the active copy changes only at a frame wrap,
    // and a load landing on the wrap bypasses the pending stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_valid  <= 1'b0;
            r_act_digits  <= '0;
            r_act_dp      <= '0;
        end else begin
            if (load) begin
                r_pend_digits <= digits;
                r_pend_dp     <= dp;
            end
            if (w_wrap) begin
                r_pend_valid <= 1'b0;
                if (load) begin
                    r_act_digits <= digits;
                    r_act_dp     <= dp;
                end else if (r_pend_valid) begin
                    r_act_digits <= r_pend_digits;
                    r_act_dp     <= r_pend_dp;
                end
            end else if (load) begin
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Leading-zero map: bit i set when nibble i and all nibbles above it are 0.
    always_comb begin
        w_lz     = '0;
        w_lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_lz_run = w_lz_run && (r_act_digits[4*i +: 4] == 4'h0);
            w_lz[i]  = w_lz_run;
        end
    end

    // Select the current digit's nibble, dp bit, anode bit and blank flag.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_onehot = '0;
        w_lz_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = r_act_digits[4*i +: 4];
                w_dp_sel    = r_act_dp[i];
                w_onehot[i] = 1'b1;
                if (i != 0) begin
                    w_lz_sel = w_lz[i];
                end
            end
        end
    end

    assign w_blank = LZB_EN && w_lz_sel;

    seg7_decode u_decode (
        .i_nibble (w_nib),
        .i_hex_en (HEX_EN),
        .i_blank  (w_blank),
        .o_seg_n  (w_seg_n)
    );

    // Registered outputs; everything dark while the display is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg    <= SEG_OFF;
            r_seg_dp <= DP_OFF;
            r_anode  <= AN_OFF;
        end else if (displayActive) begin
            r_seg    <= seg_polarity(w_seg_n, POL_LOW);
            r_seg_dp <= POL_LOW ? ~w_dp_sel : w_dp_sel;
            r_anode  <= POL_LOW ? ~w_onehot : w_onehot;
        end else begin
            r_seg    <= SEG_OFF;
            r_seg_dp <= DP_OFF;
            r_anode  <= AN_OFF;
        end
    end

    assign seg       = r_seg;
    assign segDp     = r_seg_dp;
    assign anode     = r_anode;
    assign frameDone = r_frame_done;

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameter NUM_DIGITS SHALL default to 4; it sets the number of multiplexed digits, with a legal range of 2..8.
REQ-002 Parameter SCAN_DIV SHALL default to 50000; it sets the number of clk cycles each digit is lit, with a minimum of 2.
REQ-003 Parameter ACTIVE_LOW SHALL default to 1; when 1, seg, segDp and anode are active-low, and when 0 they are active-high.
REQ-004 Parameter LZB SHALL default to 1; when 1, leading-zero blanking is enabled.
REQ-005 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 digits  in  4*NUM_DIGITS  BCD/hex nibbles; nibble i drives digit i, and digit NUM_DIGITS-1 is the most significant.
REQ-008 dp  in  NUM_DIGITS  decimal-point request per digit.
REQ-009 load  in  1  strobe that captures digits and dp into the pending register.
REQ-010 displayActive  in  1  enable; when 0, all digits SHALL be dark.
REQ-011 seg  out  7  segment pattern, bit order {g,f,e,d,c,b,a}.
REQ-012 segDp  out  1  decimal-point segment.
REQ-013 anode  out  NUM_DIGITS  one-hot digit select.
REQ-014 frameDone  out  1  one-cycle pulse at each frame wrap.

Function
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; its terminal count SHALL be called tick.
REQ-016 On tick, the digit index SHALL advance by 1; from NUM_DIGITS-1 it SHALL wrap to 0. The index width SHALL be max(1, clog2(NUM_DIGITS)).
REQ-017 frameDone SHALL pulse high for exactly the cycle in which the index wraps to 0.
REQ-018 On load, digits and dp SHALL be written to the pending register and pendValid SHALL be set.
REQ-019 Active register update:
- At a frame wrap with pendValid=1, pending SHALL be copied to the active register and pendValid SHALL be cleared.
- Displayed data therefore never changes mid-frame.
REQ-020 If load and a frame wrap coincide, the incoming digits/dp SHALL go directly to the active register and pendValid SHALL stay 0.
REQ-021 Multiple loads within one frame: the last one SHALL win.
REQ-022 Decode (active-low polarity):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- 10..15 = blank (1111111) unless HEX_EN is defined.
REQ-023 Leading-zero blanking (LZB=1): digit i>0 SHALL be blanked when it and every more-significant active nibble are 0. Digit 0 SHALL never be blanked. Blanking SHALL not suppress that digit's dp.
REQ-024 seg, segDp and anode SHALL be registered, with 1 clk of latency from an index change.
REQ-025 anode SHALL assert only bit index while displayActive=1.
REQ-026 When displayActive=0:
- All anodes SHALL be inactive and seg/segDp SHALL be all-off.
- The prescaler, index and load path SHALL keep running.
REQ-027 ACTIVE_LOW=0 SHALL invert seg, segDp and anode relative to REQ-022/REQ-025.

Reset
REQ-028 On rst_n=0, asynchronously:
- prescaler=0, index=0, pendValid=0, frameDone=0
- pending and active registers = all zeros
- anode all inactive; seg and segDp all-off
REQ-029 Reset mid-frame SHALL discard any pending load. After release, scanning SHALL restart at digit 0 with a full SCAN_DIV period.

Configuration
REQ-030 Macro DISPLAY_MUX_HEX_EN:
- Defined: nibbles 10..15 SHALL decode to A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Undefined: nibbles 10..15 SHALL show blank, and that logic SHALL be absent.

Structure
REQ-031 Package display_pkg SHALL hold the segment pattern constants for 0..F and blank, plus the typedef for a 7-bit segment vector.
REQ-032 A combinational sub-module seg7_decode (nibble, hexEn, blank -> 7-bit active-low pattern) SHALL be instantiated once on the muxed nibble.

Verification
REQ-033 NUM_DIGITS=4, SCAN_DIV=4: reset release -> anode cycles 1110,1101,1011,0111 with 4 clk per digit, and frameDone is high 1 clk per 16 clk.
REQ-034 load digits=0x0042, LZB=1 -> digits 3..2 blank, digit 1 shows 0011001, digit 0 shows 0100100; with LZB=0, digits 3..2 show 1000000.
REQ-035 load 0x1234 mid-frame -> the old value stays until frameDone, and 0x1234 appears from the next digit-0 slot.
REQ-036 load coinciding with the wrap cycle -> the new value is displayed in the same frame's digit 0; a second load 0x5678 in the same frame supersedes any earlier one.
REQ-037 Nibble 0xA: with DISPLAY_MUX_HEX_EN -> 0001000; without it -> 1111111.
REQ-038 displayActive=0 for 10 clk -> anode=1111 and seg=1111111 throughout; on re-enable, the index continues from its running value.
